// File: rtl/step_pkg.sv
// Shared state encodings for the step controller; the display/debug logic
// decodes `mode` using the same constants.
package step_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    STEP_IDLE = 2'd0,
    RUN       = 2'd1,
    STEP_FIRE = 2'd2,
    HALTED    = 2'd3
  } step_state_e;

endpackage

// File: rtl/step_controller_if.sv
// Control/status bundle between the clock generator, board I/O, the core and
// the step controller.
interface step_controller_if
  import step_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);

  logic               slow_clk;
  logic               run_sw;
  logic               step_btn;
  logic               halt;
  logic               cpu_en;
  logic [CNT_W-1:0]   step_count;
  logic               halted;
  logic [STATE_W-1:0] mode;

  modport master (
    output slow_clk, run_sw, step_btn, halt,
    input  cpu_en, step_count, halted, mode
  );

  modport slave (
    input  slow_clk, run_sw, step_btn, halt,
    output cpu_en, step_count, halted, mode
  );

endinterface

// File: rtl/debouncer.sv
// Synchronises a bouncy pushbutton and accepts a level change only after it
// has held for DEBOUNCE_CYCLES clk cycles; `rise` pulses for one cycle.
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic          r_rise;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  assign w_accept = (r_s2 != r_stable) && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1   <= din;
      r_s2   <= r_s1;
      r_rise <= w_accept && r_s2;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;
  assign rise   = r_rise;

endmodule

// File: rtl/step_controller.sv
// Turns the divided clock into one-cycle CPU enable pulses in the clk domain,
// with free-run, debounced single-step and halt modes plus a pulse counter.
module step_controller
  import step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  step_controller_if.slave  bus
);

  logic             r_slow_s1;
  logic             r_slow_s2;
  logic             r_slow_s3;
  logic             r_run_s1;
  logic             r_run_s2;
  logic             r_cpu_en;
  logic [CNT_W-1:0] r_step_count;
  step_state_e      r_state;
  step_state_e      w_state_next;
  logic             w_tick;
  logic             w_run_s;
  logic             w_press;
  logic             w_fire;
  logic             w_btn_stable;

  debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (bus.step_btn),
    .stable (w_btn_stable),
    .rise   (w_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slow_s1 <= 1'b0;
      r_slow_s2 <= 1'b0;
      r_slow_s3 <= 1'b0;
      r_run_s1  <= 1'b0;
      r_run_s2  <= 1'b0;
    end else begin
      r_slow_s1 <= bus.slow_clk;
      r_slow_s2 <= r_slow_s1;
      r_slow_s3 <= r_slow_s2;
      r_run_s1  <= bus.run_sw;
      r_run_s2  <= r_run_s1;
    end
  end

  assign w_tick  = r_slow_s2 & ~r_slow_s3;
  assign w_run_s = r_run_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STEP_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // halt outranks everything outside HALTED; inside HALTED only a press leaves
  always_comb begin
    w_state_next = r_state;
    w_fire       = 1'b0;
    if (r_state == HALTED) begin
      if (w_press) w_state_next = STEP_IDLE;
    end else if (bus.halt) begin
      w_state_next = HALTED;
    end else begin
      case (r_state)
        RUN: begin
          if (!w_run_s) w_state_next = STEP_IDLE;
          else          w_fire       = w_tick;
        end
        STEP_IDLE: begin
          if (w_run_s)      w_state_next = RUN;
          else if (w_press) w_state_next = STEP_FIRE;
        end
        STEP_FIRE: begin
          if (w_run_s) begin
            w_state_next = RUN;
          end else if (w_tick) begin
            w_fire       = 1'b1;
            w_state_next = STEP_IDLE;
          end
        end
        default: w_state_next = STEP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_en     <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_cpu_en <= w_fire;
      if (r_cpu_en) r_step_count <= r_step_count + 1'b1;
    end
  end

  assign bus.cpu_en     = r_cpu_en;
  assign bus.step_count = r_step_count;
  assign bus.halted     = (r_state == HALTED);
  assign bus.mode       = r_state;

  logic w_unused;
  assign w_unused = w_btn_stable;

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller: free-run, single-step, halt, mode
// switch, counter wrap and asynchronous reset.
module tb_step_controller;
  import step_pkg::*;

  localparam int unsigned DB = 4;
  localparam int unsigned CW = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   pulse_cnt;
  int   dbl_cnt;
  int   base;
  logic en_prev;

  step_controller_if #(.CNT_W(CW)) bus ();

  step_controller #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    pulse_cnt = 0;
    dbl_cnt   = 0;
    en_prev   = 1'b0;
  end

  always @(negedge clk) begin
    if (bus.cpu_en) pulse_cnt++;
    if (bus.cpu_en && en_prev) dbl_cnt++;
    en_prev = bus.cpu_en;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic slow_period(input int half);
    bus.slow_clk = 1'b1;
    repeat (half) cyc();
    bus.slow_clk = 1'b0;
    repeat (half) cyc();
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.slow_clk = 1'b0;
    bus.run_sw   = 1'b0;
    bus.step_btn = 1'b0;
    bus.halt     = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // clean press held long enough to debounce; ends in STEP_FIRE when run_sw=0
  task automatic do_press();
    bus.step_btn = 1'b1;
    repeat (DB + 3) cyc();
    bus.step_btn = 1'b0;
    repeat (DB + 4) cyc();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // reset state
    do_reset();
    check("rst_cpu_en", 32'(bus.cpu_en), 0);
    check("rst_count",  32'(bus.step_count), 0);
    check("rst_halted", 32'(bus.halted), 0);
    check("rst_mode",   32'(bus.mode), 0);

    // free-run, slow_clk = clk/8, 10 periods
    bus.run_sw = 1'b1;
    repeat (3) cyc();
    check("fr_mode", 32'(bus.mode), 1);
    base = pulse_cnt;
    bus.slow_clk = 1'b1;
    cyc();
    cyc();
    check("fr_lat_e2", 32'(bus.cpu_en), 0);
    cyc();
    check("fr_lat_e3", 32'(bus.cpu_en), 1);
    cyc();
    check("fr_lat_e4", 32'(bus.cpu_en), 0);
    bus.slow_clk = 1'b0;
    repeat (4) cyc();
    repeat (9) slow_period(4);
    repeat (4) cyc();
    check("fr_pulses", 32'(pulse_cnt - base), 10);
    check("fr_count",  32'(bus.step_count), 10);
    check("fr_double", 32'(dbl_cnt), 0);

    // single-step, slow_clk = clk/16
    do_reset();
    base = pulse_cnt;
    bus.step_btn = 1'b1;
    repeat (DB + 2) cyc();
    check("ss_pre_press", 32'(bus.mode), 0);
    cyc();
    check("ss_fire_mode", 32'(bus.mode), 2);
    bus.step_btn = 1'b0;
    repeat (10) cyc();
    check("ss_wait_mode", 32'(bus.mode), 2);
    check("ss_no_early",  32'(pulse_cnt - base), 0);
    bus.slow_clk = 1'b1;
    cyc();
    cyc();
    check("ss_e2_en", 32'(bus.cpu_en), 0);
    cyc();
    check("ss_e3_en",   32'(bus.cpu_en), 1);
    check("ss_e3_mode", 32'(bus.mode), 0);
    cyc();
    check("ss_count", 32'(bus.step_count), 1);
    repeat (4) cyc();
    bus.slow_clk = 1'b0;
    repeat (8) cyc();
    slow_period(8);
    check("ss_pulses", 32'(pulse_cnt - base), 1);
    check("ss_idle",   32'(bus.mode), 0);
    // 3-cycle glitch must not register as a press
    bus.step_btn = 1'b1;
    repeat (3) cyc();
    bus.step_btn = 1'b0;
    repeat (10) cyc();
    check("gl_mode", 32'(bus.mode), 0);
    slow_period(8);
    check("gl_pulses", 32'(pulse_cnt - base), 1);
    check("gl_count",  32'(bus.step_count), 1);

    // halt coincident with tick in RUN
    do_reset();
    base = pulse_cnt;
    bus.run_sw = 1'b1;
    repeat (3) cyc();
    bus.slow_clk = 1'b1;
    cyc();
    cyc();
    bus.halt = 1'b1;
    cyc();
    check("ht_en",     32'(bus.cpu_en), 0);
    check("ht_halted", 32'(bus.halted), 1);
    check("ht_mode",   32'(bus.mode), 3);
    bus.halt = 1'b0;
    repeat (5) cyc();
    bus.slow_clk = 1'b0;
    repeat (8) cyc();
    slow_period(8);
    check("ht_stay",   32'(bus.mode), 3);
    check("ht_pulses", 32'(pulse_cnt - base), 0);
    bus.step_btn = 1'b1;
    repeat (DB + 3) cyc();
    check("ht_rel_mode",   32'(bus.mode), 0);
    check("ht_rel_halted", 32'(bus.halted), 0);
    check("ht_rel_count",  32'(bus.step_count), 0);
    bus.step_btn = 1'b0;

    // run_sw rises with a tick while in STEP_FIRE
    do_reset();
    base = pulse_cnt;
    do_press();
    check("ms_fire", 32'(bus.mode), 2);
    bus.run_sw   = 1'b1;
    bus.slow_clk = 1'b1;
    cyc();
    cyc();
    check("ms_e2_mode", 32'(bus.mode), 2);
    cyc();
    check("ms_e3_mode", 32'(bus.mode), 1);
    check("ms_e3_en",   32'(bus.cpu_en), 0);
    repeat (5) cyc();
    bus.slow_clk = 1'b0;
    repeat (8) cyc();
    slow_period(8);
    slow_period(8);
    repeat (4) cyc();
    check("ms_pulses", 32'(pulse_cnt - base), 2);
    check("ms_count",  32'(bus.step_count), 2);

    // counter wrap at CNT_W=4, slow_clk = clk/2
    do_reset();
    bus.run_sw = 1'b1;
    repeat (3) cyc();
    base = pulse_cnt;
    repeat (17) slow_period(1);
    repeat (4) cyc();
    check("wr_pulses", 32'(pulse_cnt - base), 17);
    check("wr_count",  32'(bus.step_count), 1);
    check("wr_double", 32'(dbl_cnt), 0);

    // asynchronous reset with a step pending
    do_reset();
    do_press();
    bus.slow_clk = 1'b1;
    repeat (3) cyc();
    check("rs_pre_en", 32'(bus.cpu_en), 1);
    repeat (5) cyc();
    bus.slow_clk = 1'b0;
    repeat (8) cyc();
    check("rs_pre_count", 32'(bus.step_count), 1);
    do_press();
    check("rs_pending", 32'(bus.mode), 2);
    bus.slow_clk = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    check("rs_en",     32'(bus.cpu_en), 0);
    check("rs_count",  32'(bus.step_count), 0);
    check("rs_mode",   32'(bus.mode), 0);
    check("rs_halted", 32'(bus.halted), 0);
    base = pulse_cnt;
    repeat (2) cyc();
    bus.slow_clk = 1'b0;
    rst_n = 1'b1;
    repeat (4) cyc();
    slow_period(8);
    slow_period(8);
    check("rs_no_pulse", 32'(pulse_cnt - base), 0);
    check("rs_post_mode", 32'(bus.mode), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/step_controller.md
# step_controller

Consumes the divided clock from the clock generator and turns it into a single-cycle CPU enable pulse in the fast `clk` domain. It supports free-run, button-driven single-step, and a halted mode entered on CPU request. It sits between the clock generator and the RISC-V core's clock-enable input, and exports a step counter for the board display.

## Interface
- `DEBOUNCE_CYCLES`, default 50000; number of consecutive stable `clk` cycles needed to accept a `step_btn` level change.
- `CNT_W`, default 32; width of `step_count`.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `slow_clk`  in  1  divided clock from the clock generator; treated as asynchronous.
- `run_sw`  in  1  slide switch: 1 = free-run, 0 = single-step; asynchronous, not debounced.
- `step_btn`  in  1  raw pushbutton, active-high, bouncy.
- `halt`  in  1  synchronous halt request from the core (e.g. ebreak); level.
- `cpu_en`  out  1  registered one-cycle enable pulse to the core.
- `step_count`  out  CNT_W  number of `cpu_en` pulses issued; wraps.
- `halted`  out  1  high while in HALTED.
- `mode`  out  2  current state encoding.

## Operation
- **`slow_clk` path**
  - 2-flop synchronizer, then a third flop for edge detection.
  - `tick` = s2 & ~s3; it is combinational, internal, and lasts one cycle.
- **`run_sw` path:** 2-flop synchronizer giving `run_s`.
- **`step_btn` path**
  - 2-flop synchronizer, then debounce.
  - A counter increments while the synced value differs from `stable` and clears when they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES-1`, `stable` takes the synced value and the counter clears.
  - `press` = rising edge of `stable`, lasting one cycle.
- **FSM encoding:** STEP_IDLE=0, RUN=1, STEP_FIRE=2, HALTED=3.
- **Transitions:** `halt` has the highest priority. Rules are evaluated each cycle:
  - Any state except HALTED, with `halt`=1: go to HALTED, no pulse.
  - RUN: if `run_s`=0, go to STEP_IDLE. Otherwise fire a pulse on `tick`.
  - STEP_IDLE: if `run_s`=1, go to RUN. Otherwise, if `press`, go to STEP_FIRE.
  - STEP_FIRE: if `run_s`=1, go to RUN and drop the pending step. Otherwise, on `tick`, fire a pulse and go to STEP_IDLE. A `press` in this state is ignored.
  - HALTED: `press` goes to STEP_IDLE without a pulse. `run_sw` is ignored.
- **Outputs**
  - `cpu_en` is a register set from the fire condition.
  - `step_count` += 1 at the edge that ends each high cycle of `cpu_en`; it wraps from 2^CNT_W−1 to 0.
  - `halted` = (state==HALTED); `mode` = state.

## Timing
- **Reset values:**
  - state = STEP_IDLE.
  - `cpu_en`=0, `step_count`=0, `halted`=0, `mode`=0.
  - All synchronizer flops, `stable`, and the debounce counter = 0.
- **`cpu_en` latency:** a `slow_clk` rise sampled at edge k produces `tick` in the cycle after edge k+1. `cpu_en` goes high at edge k+2 for exactly one cycle.
- **Halt timing:** `halt` seen in cycle n means no `cpu_en` at edge n+1. `halted`=1 from edge n+1.
- **Same-cycle conflicts:**
  - `halt` with `tick` in the same cycle: `halt` wins.
  - `run_s` rising with `tick` in STEP_FIRE: go to RUN, no pulse that cycle.
- **Maximum pulse rate:** with `slow_clk` = clk/2, `cpu_en` pulses every 2 cycles. `cpu_en` is never high on two consecutive cycles.
- **Debounce latency:** `press` arrives 2 + `DEBOUNCE_CYCLES` cycles after a clean button rise. A glitch shorter than `DEBOUNCE_CYCLES` produces no press.
- **Reset mid-operation:** `rst_n` low clears everything immediately, including a pending STEP_FIRE and an in-flight pulse. The first post-reset pulse needs a fresh `press` or `run_s`=1.

## Structure
- Shared package/header `step_pkg`: state encodings (STEP_IDLE, RUN, STEP_FIRE, HALTED) and the 2-bit state width. The core's debug/display logic decodes `mode` with the same constants.
- One sub-module, `debouncer`:
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `rst_n`, `din`, `stable`, `rise`.
  - It contains its own 2-flop synchronizer.
- Synchronizers, edge detect, FSM and counter live in `step_controller`.

## Test plan
- **Free-run:** `run_sw`=1, `slow_clk` = clk/8 for 10 periods → 10 one-cycle `cpu_en` pulses, each 3 edges after a `slow_clk` rise; `step_count`=10.
- **Single-step:** `DEBOUNCE_CYCLES`=4, `run_sw`=0, `slow_clk` = clk/16, one clean press → exactly one pulse at the next `tick`; mode 0→2→0; `step_count`=1. A 3-cycle glitch → no pulse.
- **Halt:** `halt`=1 in the same cycle as `tick` in RUN → no pulse; `halted`=1, `mode`=3. A press returns to `mode`=0 with `step_count` unchanged.
- **Mode switch:** `run_sw` 0→1 while in STEP_FIRE → `mode`=1 after sync, pending step dropped, pulses resume on subsequent ticks.
- **Wrap:** `CNT_W`=4, 17 pulses → `step_count`=1.
- **Reset:** assert `rst_n`=0 mid-STEP_FIRE → all outputs 0 immediately; no pulse after release until a new press.
